fact_accel_if: RTL and testbench
================================

# fact_accel_if

Parametrised memory-mapped factorial accelerator for the MIPS SoC bus. It holds a 4-word register window (operand, go, status, result) and an internal iterative multiply engine that computes n! one multiply per cycle. It also detects result-width overflow and exposes a busy flag. Operand and result widths are generic, so the same block serves 4-bit/32-bit and wider SoC variants.

## Interface
- N_W, 4, operand width; n ranges 0..2^N_W-1.
- R_W, 32, result width; 1 ≤ N_W ≤ R_W ≤ 32.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- A  in  2  word address: 0 = N, 1 = GO, 2 = STATUS, 3 = RESULT.
- WE  in  1  write enable, sampled on clk rising edge.
- WD  in  N_W  write data.
- RD  out  32  read data, combinational from A, zero-extended.

## Operation
- Address decode:
  - A=0 WE: N register ← WD.
  - A=1 WE: Go register ← WD[0].
  - A=1 WE with WD[0]=1: go_cmb. Writes to A=2/3 are ignored.
- go_pulse: one-cycle registered copy of go_cmb.
  - go_pulse in IDLE starts the engine.
  - go_pulse while Busy is ignored: no restart, flags untouched.
- go_cmb while IDLE clears ResDone and ResErr on the same edge it is latched. go_cmb while Busy has no effect on the flags.
- Engine FSM:
  - IDLE → MUL on go_pulse: acc ← 1, cnt ← N (N sampled on that edge).
  - MUL, cnt ≤ 1: → IDLE, Result ← acc, ResDone ← 1.
  - MUL, cnt > 1: forms the full 2·R_W product p = acc·cnt.
    - If p[2R_W-1:R_W] ≠ 0: → IDLE, ResErr ← 1, ResDone ← 1, Result unchanged.
    - Otherwise acc ← p[R_W-1:0], cnt ← cnt−1, stay in MUL.
- Busy = (state == MUL).
- Writing N while Busy updates N only; the running computation uses its latched cnt.
- Read map:
  - A=0: {0, N}.
  - A=1: {31'b0, Go}.
  - A=2: {29'b0, Busy, ResDone, ResErr}.
  - A=3: {0, Result}.
- Reset (async, any time including mid-computation):
  - Clears N, Go, go_pulse, acc, cnt, Result, ResDone and ResErr to 0, and sets state to IDLE.
  - RD for every address reads 0 immediately.

## Timing
- Go write on edge k. go_pulse is high during cycle k→k+1. MUL is entered on edge k+1.
- Completion edge = k+2+max(n−1,0). ResDone and Result are visible right after it.
  - n=0 or n=1: done at edge k+2, Result=1.
  - n=5: done at edge k+6, Result=120.
- Overflow aborts on the first overflowing multiply, so the error completes no later than a success would.
- Busy is high from edge k+1 to the completion edge (exclusive). It is never high for fewer than 1 cycle.
- ResDone and ResErr are sticky until the next accepted go_cmb or reset.
- Go-register reads reflect a write on the next cycle. The status bits change only on clk edges or reset.

## Test plan
- Reset: assert rst asynchronously mid-cycle. RD reads 0 at A=0..3, Busy=0.
- 5!: write N=5, then GO=1. Busy=1 for 5 cycles, then STATUS=3'b010 and RESULT=120 at edge k+6.
- 0! and 1!: each completes at k+2 with RESULT=1 and ResErr=0.
- Overflow (R_W=32): n=12 gives RESULT=479001600 (0x1C8CFC00). A following n=13 gives STATUS=3'b011 and RESULT still 479001600.
- Go while busy: start n=10, then rewrite N=3 and GO=1 mid-run. Busy stays high, the flags are not cleared, and RESULT=3628800.
- Reset mid-op: start n=12, assert rst after 4 cycles. All state is 0. A fresh n=4 run then gives RESULT=24.
- Parameter sweep: N_W=5, R_W=16. Check 8!=40320 succeeds and 9! flags ResErr.

Source files
------------

// File: rtl/fact_accel_if.sv
// -----------------------------------------------------------------------------
// fact_accel_if
//
// Memory-mapped factorial accelerator for the MIPS SoC bus. It holds a 4-word
// register window and an iterative engine that computes n!, one multiply per
// clock. A multiply whose product no longer fits in R_W bits aborts the run and
// raises ResErr.
//
// Register window (word address A):
//   0  N       rw  operand n (N_W bits, zero-extended on read)
//   1  GO      rw  bit 0; writing 1 launches a run when the engine is idle
//   2  STATUS  ro  {29'b0, Busy, ResDone, ResErr}
//   3  RESULT  ro  last successful result (R_W bits, zero-extended on read)
//
// Ports:
//   clk  in   1     system clock, all state on the rising edge
//   rst  in   1     asynchronous, active-high reset
//   A    in   2     word address
//   WE   in   1     write enable, sampled on the rising edge of clk
//   WD   in   N_W   write data
//   RD   out  32    read data, combinational from A
//
// Bus handshake: there is no valid/ready pair. A write is accepted on every
// rising edge where WE is high; a read is a pure combinational decode of A
// with no wait states.
// -----------------------------------------------------------------------------
module fact_accel_if #(
   parameter int N_W = 4,
   parameter int R_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     A,
   input  logic           WE,
   input  logic [N_W-1:0] WD,
   output logic [31:0]    RD
);

   localparam logic [1:0] ADDR_N      = 2'd0;
   localparam logic [1:0] ADDR_GO     = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_RESULT = 2'd3;

   localparam logic [N_W-1:0] CNT_ONE = N_W'(1);
   localparam logic [R_W-1:0] ACC_ONE = R_W'(1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   // Bus-side registers
   logic [N_W-1:0] n_q;
   logic           go_q;
   logic           go_pulse_q;

   // Engine registers
   state_t         state_q;
   logic [R_W-1:0] acc_q;
   logic [N_W-1:0] cnt_q;
   logic [R_W-1:0] res_q;
   logic           done_q;
   logic           err_q;

   logic             go_cmb;
   logic             busy;
   logic [2*R_W-1:0] prod;
   logic             prod_ovf;

   // A GO write with bit 0 set is the launch command.
   assign go_cmb = WE && (A == ADDR_GO) && WD[0];
   assign busy   = (state_q == S_MUL);

   // Full-width product so the upper half can be tested for overflow.
   // N_W <= R_W, so cnt always fits in the zero-extended operand.
   assign prod     = {{R_W{1'b0}}, acc_q} * {{(2*R_W-N_W){1'b0}}, cnt_q};
   assign prod_ovf = |prod[2*R_W-1:R_W];

   // ---------------------------------------------------------------------------
   // Bus-side register file. N may be rewritten at any time; a running
   // computation keeps using its own latched copy in cnt_q.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q        <= '0;
         go_q       <= 1'b0;
         go_pulse_q <= 1'b0;
      end else begin
         go_pulse_q <= go_cmb;
         if (WE && (A == ADDR_N)) begin
            n_q <= WD;
         end
         if (WE && (A == ADDR_GO)) begin
            go_q <= WD[0];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Engine FSM with registered result and flags.
   // IDLE: a launch command clears the sticky flags on the edge it is written;
   //       the registered go pulse one cycle later moves the engine into MUL.
   // MUL:  multiply acc by the descending counter until cnt <= 1, or abort on
   //       the first multiply that overflows R_W bits (Result kept).
   // Launch commands seen while in MUL are ignored entirely.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (go_cmb) begin
                  done_q <= 1'b0;
                  err_q  <= 1'b0;
               end
               if (go_pulse_q) begin
                  state_q <= S_MUL;
                  acc_q   <= ACC_ONE;
                  cnt_q   <= n_q;
               end
            end
            S_MUL: begin
               if (cnt_q <= CNT_ONE) begin
                  // 0! and 1! land here on the first MUL cycle with acc = 1.
                  state_q <= S_IDLE;
                  res_q   <= acc_q;
                  done_q  <= 1'b1;
               end else if (prod_ovf) begin
                  state_q <= S_IDLE;
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
               end else begin
                  acc_q <= prod[R_W-1:0];
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Read decode. Every source is a register, so reset forces RD to 0 at once.
   // ---------------------------------------------------------------------------
   always_comb begin
      RD = 32'd0;
      case (A)
         ADDR_N:      RD = 32'(n_q);
         ADDR_GO:     RD = {31'd0, go_q};
         ADDR_STATUS: RD = {29'd0, busy, done_q, err_q};
         ADDR_RESULT: RD = 32'(res_q);
         default:     RD = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_fact_accel_if.sv
// -----------------------------------------------------------------------------
// tb_fact_accel_if
//
// Directed bench for fact_accel_if. Two instances share clk and rst:
//   dut0  N_W=4, R_W=32  (default build)
//   dut1  N_W=5, R_W=16  (narrow-result build)
// Each scenario task drives the bus, waits an exact number of edges and
// compares RD against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fact_accel_if;

   logic        clk;
   logic        rst;

   logic [1:0]  a0;
   logic        we0;
   logic [3:0]  wd0;
   logic [31:0] rd0;

   logic [1:0]  a1;
   logic        we1;
   logic [4:0]  wd1;
   logic [31:0] rd1;

   int checks;
   int errors;

   fact_accel_if #(.N_W(4), .R_W(32)) dut0 (
      .clk (clk),
      .rst (rst),
      .A   (a0),
      .WE  (we0),
      .WD  (wd0),
      .RD  (rd0)
   );

   fact_accel_if #(.N_W(5), .R_W(16)) dut1 (
      .clk (clk),
      .rst (rst),
      .A   (a1),
      .WE  (we1),
      .WD  (wd1),
      .RD  (rd1)
   );

   // ---------------------------------------------------------------- clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------- driver tasks
   // One bus write: set up after the falling edge, sampled on the next rising
   // edge (edge k), returns 1 ns after edge k.
   task automatic wr(input int sel, input logic [1:0] a, input logic [4:0] d);
      @(negedge clk);
      if (sel == 0) begin
         a0 = a; we0 = 1'b1; wd0 = d[3:0];
      end else begin
         a1 = a; we1 = 1'b1; wd1 = d;
      end
      @(posedge clk);
      #1;
      we0 = 1'b0;
      we1 = 1'b0;
   endtask

   task automatic rd(input int sel, input logic [1:0] a, output logic [31:0] d);
      if (sel == 0) begin
         a0 = a; #1; d = rd0;
      end else begin
         a1 = a; #1; d = rd1;
      end
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   // Launch n! and check the exact completion edge. done_after is the number
   // of edges from the GO write to completion.
   task automatic run_check(input int sel, input logic [4:0] n, input int done_after,
                            input logic [2:0] exp_st, input logic [31:0] exp_res,
                            input string name);
      logic [31:0] d;
      wr(sel, 2'd0, n);
      wr(sel, 2'd1, 5'd1);
      rd(sel, 2'd2, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL %s status_at_go got=%h exp=%h", name, d, 32'd0);
      end
      for (int i = 1; i < done_after; i++) begin
         next_edge();
         rd(sel, 2'd2, d);
         checks++;
         if (d !== 32'd4) begin
            errors++;
            $display("FAIL %s busy_cycle%0d got=%h exp=%h", name, i, d, 32'd4);
         end
      end
      next_edge();
      rd(sel, 2'd2, d);
      checks++;
      if (d !== {29'd0, exp_st}) begin
         errors++;
         $display("FAIL %s status_done got=%h exp=%h", name, d, {29'd0, exp_st});
      end
      rd(sel, 2'd3, d);
      checks++;
      if (d !== exp_res) begin
         errors++;
         $display("FAIL %s result got=%0d exp=%0d", name, d, exp_res);
      end
   endtask

   task automatic check_all_zero(input string name);
      logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
         rd(0, 2'(i), d);
         checks++;
         if (d !== 32'd0) begin
            errors++;
            $display("FAIL %s dut0_addr%0d got=%h exp=0", name, i, d);
         end
      end
      rd(1, 2'd2, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL %s dut1_status got=%h exp=0", name, d);
      end
   endtask

   // ---------------------------------------------------------------- scenarios
   task automatic test_reset();
      // Put live state in dut0 (N, Go, a run in progress), then reset mid-cycle.
      wr(0, 2'd0, 5'd7);
      wr(0, 2'd1, 5'd1);
      next_edge();
      next_edge();
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_go_reg();
      logic [31:0] d;
      wr(0, 2'd1, 5'd0);
      rd(0, 2'd1, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL go_reg go0 got=%h exp=0", d);
      end
      next_edge();
      rd(0, 2'd2, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL go_reg no_start got=%h exp=0", d);
      end
   endtask

   task automatic test_fact5();
      logic [31:0] d;
      run_check(0, 5'd5, 6, 3'b010, 32'd120, "fact5");
      // Writes to STATUS and RESULT are ignored.
      wr(0, 2'd3, 5'd15);
      wr(0, 2'd2, 5'd7);
      rd(0, 2'd3, d);
      checks++;
      if (d !== 32'd120) begin
         errors++;
         $display("FAIL ro_result got=%0d exp=120", d);
      end
      rd(0, 2'd2, d);
      checks++;
      if (d !== 32'd2) begin
         errors++;
         $display("FAIL ro_status got=%h exp=2", d);
      end
   endtask

   task automatic test_small();
      run_check(0, 5'd0, 2, 3'b010, 32'd1, "fact0");
      run_check(0, 5'd1, 2, 3'b010, 32'd1, "fact1");
   endtask

   task automatic test_overflow();
      run_check(0, 5'd12, 13, 3'b010, 32'd479001600, "fact12");
      // 13! overflows on the last multiply (cnt=2), one edge before a success.
      run_check(0, 5'd13, 13, 3'b011, 32'd479001600, "fact13_ovf");
   endtask

   task automatic test_go_while_busy();
      logic [31:0] d;
      wr(0, 2'd0, 5'd10);
      wr(0, 2'd1, 5'd1);       // edge k
      next_edge();             // k+1
      next_edge();             // k+2
      wr(0, 2'd0, 5'd3);       // k+3
      wr(0, 2'd1, 5'd1);       // k+4
      for (int e = 4; e < 11; e++) begin
         if (e > 4) next_edge();
         rd(0, 2'd2, d);
         checks++;
         if (d !== 32'd4) begin
            errors++;
            $display("FAIL busy_go edge%0d got=%h exp=4", e, d);
         end
      end
      rd(0, 2'd0, d);
      checks++;
      if (d !== 32'd3) begin
         errors++;
         $display("FAIL busy_go n_readback got=%0d exp=3", d);
      end
      next_edge();             // k+11
      rd(0, 2'd2, d);
      checks++;
      if (d !== 32'd2) begin
         errors++;
         $display("FAIL busy_go status_done got=%h exp=2", d);
      end
      rd(0, 2'd3, d);
      checks++;
      if (d !== 32'd3628800) begin
         errors++;
         $display("FAIL busy_go result got=%0d exp=3628800", d);
      end
      next_edge();             // k+12: the ignored GO must not restart
      rd(0, 2'd2, d);
      checks++;
      if (d !== 32'd2) begin
         errors++;
         $display("FAIL busy_go no_restart got=%h exp=2", d);
      end
   endtask

   task automatic test_reset_mid_op();
      wr(0, 2'd0, 5'd12);
      wr(0, 2'd1, 5'd1);
      repeat (4) next_edge();
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("reset_mid");
      @(negedge clk);
      rst = 1'b0;
      run_check(0, 5'd4, 5, 3'b010, 32'd24, "fact4_after_reset");
   endtask

   task automatic test_sweep();
      logic [31:0] d;
      wr(1, 2'd0, 5'd31);
      rd(1, 2'd0, d);
      checks++;
      if (d !== 32'd31) begin
         errors++;
         $display("FAIL sweep n31 got=%0d exp=31", d);
      end
      run_check(1, 5'd8, 9, 3'b010, 32'd40320, "sweep_fact8");
      // 9! overflows 16 bits at the cnt=3 multiply (60480*3).
      run_check(1, 5'd9, 8, 3'b011, 32'd40320, "sweep_fact9_ovf");
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      a0 = 2'd0; we0 = 1'b0; wd0 = '0;
      a1 = 2'd0; we1 = 1'b0; wd1 = '0;
      repeat (2) @(posedge clk);
      #3;
      check_all_zero("por");
      rst = 1'b0;

      test_reset();
      test_go_reg();
      test_fact5();
      test_small();
      test_overflow();
      test_go_while_busy();
      test_reset_mid_op();
      test_sweep();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
